// File: rtl/sprite_mover.sv
// sprite_mover: frame-rate position generator for a grid-bound sprite.
//
// The sprite's signed top-left corner advances once per video frame in the current
// direction. A single-entry buffer holds the latest turn request until the sprite is
// on the tile grid. A reversal is the exception: it is honoured at once, even off-grid.
// A wall collision seen during a frame makes the next update snap the sprite back to
// the last tile it was aligned on and stop it. X wraps through the horizontal tunnel.
//
// Ports:
//   clk, resetN            clock, asynchronous active-low reset
//   start_of_frame         one-cycle pulse; the frame update happens on this cycle
//   pause                  hold position on frame updates
//   dir_req_valid, dir_req turn request strobe and direction (0 up, 1 right, 2 down, 3 left)
//   wall_hit               collision indication, any cycle of the frame
//   boost                  (only with SPRITE_MOVER_BOOST_EN) double step on this update
//   top_left_x/_y          signed 11-bit sprite corner
//   cur_dir, moving        current direction, 1 while in MOVING state
//   aligned                corner sits on the tile grid
//
// Optional feature macro: SPRITE_MOVER_BOOST_EN (adds the boost input).
module sprite_mover #(
  parameter int INIT_X         = 304,
  parameter int INIT_Y         = 224,
  parameter int TILE           = 16,
  parameter int SPEED          = 2,
  parameter int SCREEN_W       = 640,
  parameter int OBJECT_WIDTH_X = 16
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               start_of_frame,
  input  logic               pause,
  input  logic               dir_req_valid,
  input  logic [1:0]         dir_req,
  input  logic               wall_hit,
`ifdef SPRITE_MOVER_BOOST_EN
  input  logic               boost,
`endif
  output logic signed [10:0] top_left_x,
  output logic signed [10:0] top_left_y,
  output logic [1:0]         cur_dir,
  output logic               moving,
  output logic               aligned
);

  localparam int ALIGN_BITS = $clog2(TILE);
  localparam logic signed [11:0] WRAP_LO_C = 12'(-OBJECT_WIDTH_X);
  localparam logic signed [11:0] WRAP_HI_C = 12'(SCREEN_W);
  localparam logic signed [11:0] X_LO_C    = 12'(SCREEN_W - TILE);
  localparam logic signed [11:0] X_HI_C    = 12'(TILE - OBJECT_WIDTH_X);

  typedef enum logic {STOPPED = 1'b0, MOVING = 1'b1} state_e;

  state_e            state_q, state_d;
  logic signed [10:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [10:0] last_x_q, last_x_d, last_y_q, last_y_d;
  logic [1:0]        cur_dir_q, cur_dir_d, pend_dir_q, pend_dir_d;
  logic              pend_valid_q, pend_valid_d, hit_q, hit_d;
  logic              aligned_q, aligned_d;

  logic              hit_now_s, turn_ok_s, write_pos_s;
  logic [1:0]        step_dir_s;
  logic signed [11:0] step_s, nx_s, ny_s;

  function automatic logic is_aligned(input logic signed [10:0] x, input logic signed [10:0] y);
    return (x[ALIGN_BITS-1:0] == '0) && (y[ALIGN_BITS-1:0] == '0);
  endfunction

  // Candidate stepped position in the direction this update would use, with tunnel wrap.
  always_comb begin
`ifdef SPRITE_MOVER_BOOST_EN
    step_s = boost ? 12'(2 * SPEED) : 12'(SPEED);
`else
    step_s = 12'(SPEED);
`endif
    step_dir_s = turn_ok_s ? pend_dir_q : cur_dir_q;
    nx_s = {pos_x_q[10], pos_x_q};
    ny_s = {pos_y_q[10], pos_y_q};
    case (step_dir_s)
      2'd0:    ny_s = ny_s - step_s;
      2'd1:    nx_s = nx_s + step_s;
      2'd2:    ny_s = ny_s + step_s;
      2'd3:    nx_s = nx_s - step_s;
      default: nx_s = nx_s;
    endcase
    if (nx_s < WRAP_LO_C) begin
      nx_s = X_LO_C;
    end else if (nx_s > WRAP_HI_C) begin
      nx_s = X_HI_C;
    end else begin
      nx_s = nx_s;
    end
  end

  // A wall hit in the start_of_frame cycle still belongs to the frame being closed.
  assign hit_now_s = hit_q | wall_hit;
  // Reverse direction is the opposite code: flipping bit 1 maps 0<->2 and 1<->3.
  assign turn_ok_s = pend_valid_q && (aligned_q || (pend_dir_q == (cur_dir_q ^ 2'd2)));

  // Next-state logic: frame update priority, then request latch and alignment tracking.
  always_comb begin
    state_d      = state_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    last_x_d     = last_x_q;
    last_y_d     = last_y_q;
    cur_dir_d    = cur_dir_q;
    pend_dir_d   = pend_dir_q;
    pend_valid_d = pend_valid_q;
    hit_d        = hit_now_s;
    write_pos_s  = 1'b0;
    if (start_of_frame) begin
      hit_d = 1'b0;
      if (pause) begin
        state_d = state_q;
      end else if ((state_q == MOVING) && hit_now_s) begin
        pos_x_d     = last_x_q;
        pos_y_d     = last_y_q;
        state_d     = STOPPED;
        write_pos_s = 1'b1;
      end else if (turn_ok_s) begin
        cur_dir_d    = pend_dir_q;
        pend_valid_d = 1'b0;
        state_d      = MOVING;
        pos_x_d      = nx_s[10:0];
        pos_y_d      = ny_s[10:0];
        write_pos_s  = 1'b1;
      end else if (state_q == MOVING) begin
        pos_x_d     = nx_s[10:0];
        pos_y_d     = ny_s[10:0];
        write_pos_s = 1'b1;
      end else begin
        state_d = STOPPED;
      end
    end else begin
      state_d = state_q;
    end
    // Latched after the update so a request in the frame cycle waits for the next frame.
    if (dir_req_valid) begin
      pend_valid_d = 1'b1;
      pend_dir_d   = dir_req;
    end else begin
      pend_dir_d = pend_dir_d;
    end
    if (write_pos_s && is_aligned(pos_x_d, pos_y_d)) begin
      last_x_d = pos_x_d;
      last_y_d = pos_y_d;
    end else begin
      last_x_d = last_x_q;
    end
    aligned_d = is_aligned(pos_x_d, pos_y_d);
  end

  // State and position registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= STOPPED;
      pos_x_q      <= 11'(INIT_X);
      pos_y_q      <= 11'(INIT_Y);
      last_x_q     <= 11'(INIT_X);
      last_y_q     <= 11'(INIT_Y);
      cur_dir_q    <= 2'd3;
      pend_dir_q   <= 2'd0;
      pend_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      aligned_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      last_x_q     <= last_x_d;
      last_y_q     <= last_y_d;
      cur_dir_q    <= cur_dir_d;
      pend_dir_q   <= pend_dir_d;
      pend_valid_q <= pend_valid_d;
      hit_q        <= hit_d;
      aligned_q    <= aligned_d;
    end
  end

  assign top_left_x = pos_x_q;
  assign top_left_y = pos_y_q;
  assign cur_dir    = cur_dir_q;
  assign moving     = (state_q == MOVING);
  assign aligned    = aligned_q;

`ifdef SPRITE_MOVER_BOOST_EN
  sprite_mover_boost_chk #(.TILE(TILE), .SPEED(SPEED)) u_boost_chk (
    .clk            (clk),
    .resetN         (resetN),
    .start_of_frame (start_of_frame),
    .boost          (boost)
  );
`endif

endmodule

`ifdef SPRITE_MOVER_BOOST_EN
// sprite_mover_boost_chk: flags a boosted frame update in a configuration where the
// doubled step would no longer land on the tile grid.
module sprite_mover_boost_chk #(
  parameter int TILE  = 16,
  parameter int SPEED = 2
) (
  input logic clk,
  input logic resetN,
  input logic start_of_frame,
  input logic boost
);
  a_boost_divides_tile : assert property (@(posedge clk) disable iff (!resetN)
    (start_of_frame && boost) |-> ((TILE % (2 * SPEED)) == 0));
endmodule
`endif

// File: tb/tb_sprite_mover.sv
// Self-checking bench for sprite_mover: directed walk through the main scenarios, then
// randomized frames, all compared each cycle against a behavioural model.
module tb_sprite_mover;

  logic               clk = 1'b0;
  logic               resetN;
  logic               sof, ps, rv, wh;
  logic [1:0]         rq;
  logic signed [10:0] top_left_x, top_left_y;
  logic [1:0]         cur_dir;
  logic               moving, aligned;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model state (plain integers)
  int mx, my, lx, ly, mdir, mpdir;
  bit mmov, mpend, mhit;

  always #5 clk = ~clk;

  sprite_mover dut (
    .clk            (clk),
    .resetN         (resetN),
    .start_of_frame (sof),
    .pause          (ps),
    .dir_req_valid  (rv),
    .dir_req        (rq),
    .wall_hit       (wh),
`ifdef SPRITE_MOVER_BOOST_EN
    .boost          (1'b0),
`endif
    .top_left_x     (top_left_x),
    .top_left_y     (top_left_y),
    .cur_dir        (cur_dir),
    .moving         (moving),
    .aligned        (aligned)
  );

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_aligned(input int x, input int y);
    return ((x % 16) == 0) && ((y % 16) == 0);
  endfunction

  function automatic int wrap11(input int v);
    return ((v + 1024) & 2047) - 1024;
  endfunction

  task automatic model_reset();
    mx = 304; my = 224; lx = 304; ly = 224;
    mdir = 3; mpdir = 0; mmov = 0; mpend = 0; mhit = 0;
  endtask

  task automatic model_move(input int d);
    case (d)
      0: my = my - 2;
      1: mx = mx + 2;
      2: my = my + 2;
      default: mx = mx - 2;
    endcase
    if (mx < -16) mx = 624;
    else if (mx > 640) mx = 0;
    my = wrap11(my);
    if (m_aligned(mx, my)) begin
      lx = mx; ly = my;
    end
  endtask

  task automatic model_clock(input bit f, input bit p, input bit v, input int r, input bit w);
    bit hn;
    hn = mhit | w;
    if (f) begin
      if (p) begin
      end else if (mmov && hn) begin
        mx = lx; my = ly; mmov = 0;
      end else if (mpend && (m_aligned(mx, my) || mpdir == ((mdir + 2) % 4))) begin
        mdir = mpdir; mpend = 0; mmov = 1;
        model_move(mdir);
      end else if (mmov) begin
        model_move(mdir);
      end
      mhit = 0;
    end else begin
      mhit = hn;
    end
    if (v) begin
      mpend = 1; mpdir = r;
    end
  endtask

  task automatic check_all();
    check("x", int'(top_left_x), mx);
    check("y", int'(top_left_y), my);
    check("dir", int'(cur_dir), mdir);
    check("moving", int'(moving), int'(mmov));
    check("aligned", int'(aligned), int'(m_aligned(mx, my)));
  endtask

  task automatic cyc(input bit f, input bit v, input int r, input bit w, input bit p);
    sof = f; rv = v; rq = 2'(r); wh = w; ps = p;
    @(posedge clk);
    model_clock(f, p, v, r, w);
    #1;
    check_all();
  endtask

  task automatic idle(input bit v, input int r, input bit w);
    cyc(1'b0, v, r, w, 1'b0);
  endtask

  task automatic frame(input bit v, input int r, input bit w, input bit p);
    idle(1'b0, 0, 1'b0);
    cyc(1'b1, v, r, w, p);
  endtask

  task automatic mid_reset();
    resetN = 1'b0;
    #1;
    model_reset();
    check_all();
    #2;
    resetN = 1'b1;
  endtask

  initial begin
    resetN = 1'b0;
    sof = 1'b0; ps = 1'b0; rv = 1'b0; rq = 2'd0; wh = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    resetN = 1'b1;

    // idle frames: nothing moves
    repeat (5) frame(1'b0, 0, 1'b0, 1'b0);
    check("tp1_x", int'(top_left_x), 304);
    check("tp1_moving", int'(moving), 0);

    // request right, then request up while off-grid
    idle(1'b1, 1, 1'b0);
    frame(1'b0, 0, 1'b0, 1'b0);
    check("tp2_x306", int'(top_left_x), 306);
    idle(1'b1, 0, 1'b0);
    repeat (7) frame(1'b0, 0, 1'b0, 1'b0);
    check("tp3_x320", int'(top_left_x), 320);
    check("tp3_dir_right", int'(cur_dir), 1);
    frame(1'b0, 0, 1'b0, 1'b0);
    check("tp3_y222", int'(top_left_y), 222);
    check("tp3_dir_up", int'(cur_dir), 0);

    // wall hit: revert to aligned tile and stop
    idle(1'b0, 0, 1'b1);
    frame(1'b0, 0, 1'b0, 1'b0);
    check("tp5_y224", int'(top_left_y), 224);
    check("tp5_stopped", int'(moving), 0);

    // reversal off-grid
    idle(1'b1, 1, 1'b0);
    repeat (2) frame(1'b0, 0, 1'b0, 1'b0);
    idle(1'b1, 3, 1'b0);
    frame(1'b0, 0, 1'b0, 1'b0);
    check("tp4_x322", int'(top_left_x), 322);
    check("tp4_dir_left", int'(cur_dir), 3);

    // walk into the tunnel
    for (int i = 0; i < 400 && mx != -16; i++) frame(1'b0, 0, 1'b0, 1'b0);
    check("tp6_x_m16", int'(top_left_x), -16);
    frame(1'b0, 0, 1'b0, 1'b0);
    check("tp6_wrap", int'(top_left_x), 624);
    idle(1'b0, 0, 1'b1);
    frame(1'b0, 0, 1'b0, 1'b1);
    check("tp6_pause_hold", int'(top_left_x), 624);
    frame(1'b0, 0, 1'b0, 1'b0);
    check("tp6_hit_cleared", int'(top_left_x), 622);
    check("tp6_moving", int'(moving), 1);

    // randomized frames
    for (int f = 0; f < 300; f++) begin
      int n;
      if (f == 150) mid_reset();
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++)
        idle(($urandom % 4) == 0, int'($urandom % 4), ($urandom % 16) == 0);
      cyc(1'b1, ($urandom % 4) == 0, int'($urandom % 4), ($urandom % 16) == 0,
          ($urandom % 8) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
